// File: rtl/median_output_buffer.sv
// rtl/median_output_buffer.sv - captures a filtered binary frame into 8 bit-banks and drains it as packed bytes.
// Optional fgCount output is enabled by defining MEDIAN_OUTBUF_FGCOUNT_EN.
module median_output_buffer #(
    parameter int   IMG_W        = 256,
    parameter int   IMG_H        = 256,
    parameter logic BORDER_VALUE = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dataIn,
    input  logic        writeEnable,
    input  logic [7:0]  xMedianAddress,
    input  logic [7:0]  yMedianAddress,
    input  logic        filterDone,
    output logic [7:0]  txData,
    output logic        txValid,
    input  logic        txReady,
    output logic        bufferBusy,
    output logic        readoutDone,
    output logic        writeDropped
`ifdef MEDIAN_OUTBUF_FGCOUNT_EN
    ,
    output logic [16:0] fgCount
`endif
);

    localparam int         COLS      = IMG_W / 8;
    localparam int         DEPTH     = COLS * IMG_H;
    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [12:0] LAST_BYTE = 13'(DEPTH - 1);
    localparam logic [4:0]  LAST_COL  = 5'(COLS - 1);
    localparam logic [7:0]  LAST_ROW  = 8'(IMG_H - 1);

    localparam logic [1:0] S_CAPTURE = 2'd0;
    localparam logic [1:0] S_READ    = 2'd1;
    localparam logic [1:0] S_LOAD    = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    // One column of this array per bank: bit b of a word holds pixel x with x[2:0]==b.
    logic [7:0] mem [0:(1<<AW)-1];
    logic [7:0] bank_rd_q;

    logic [1:0]  state_q, state_d;
    logic [12:0] byte_cnt_q, byte_cnt_d;
    logic [4:0]  col_q, col_d;
    logic [7:0]  row_q, row_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dropped_q, dropped_d;
    logic        fd_prev_q, fd_prev_d;

    logic          in_range;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          row_border;
    logic          last_accept;
    logic [7:0]    load_byte;

    assign in_range    = ({1'b0, xMedianAddress} < 9'(IMG_W)) && ({1'b0, yMedianAddress} < 9'(IMG_H));
    assign wr_en       = !reset && (state_q == S_CAPTURE) && writeEnable && in_range;
    assign wr_addr     = AW'(yMedianAddress) * AW'(COLS) + AW'(xMedianAddress[7:3]);
    assign rd_addr     = byte_cnt_q[AW-1:0];
    assign row_border  = (row_q == 8'd0) || (row_q == LAST_ROW);
    assign last_accept = (state_q == S_HOLD) && txReady && (byte_cnt_q == LAST_BYTE);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr][xMedianAddress[2:0]] <= dataIn;
        end
        bank_rd_q <= mem[rd_addr];
    end

    // Leftmost pixel of the byte goes to the MSB; border pixels are overridden.
    always_comb begin
        load_byte = '0;
        for (int b = 0; b < 8; b++) begin
            if (row_border || (b == 0 && col_q == 5'd0) || (b == 7 && col_q == LAST_COL)) begin
                load_byte[7-b] = BORDER_VALUE;
            end else begin
                load_byte[7-b] = bank_rd_q[b];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        col_d      = col_q;
        row_d      = row_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dropped_d  = dropped_q | (busy_q & writeEnable);
        fd_prev_d  = filterDone;

        case (state_q)
            S_CAPTURE: begin
                byte_cnt_d = '0;
                col_d      = '0;
                row_d      = '0;
                if (filterDone && !fd_prev_q) begin
                    state_d = S_READ;
                    busy_d  = 1'b1;
                end
            end
            S_READ: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                tx_data_d  = load_byte;
                tx_valid_d = 1'b1;
                state_d    = S_HOLD;
            end
            S_HOLD: begin
                if (txReady) begin
                    tx_valid_d = 1'b0;
                    if (byte_cnt_q == LAST_BYTE) begin
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        byte_cnt_d = '0;
                        state_d    = S_CAPTURE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 13'd1;
                        if (col_q == LAST_COL) begin
                            col_d = '0;
                            row_d = row_q + 8'd1;
                        end else begin
                            col_d = col_q + 5'd1;
                        end
                        state_d = S_READ;
                    end
                end
            end
            default: begin
                state_d = S_CAPTURE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_CAPTURE;
            byte_cnt_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dropped_q  <= 1'b0;
            fd_prev_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            col_q      <= col_d;
            row_q      <= row_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dropped_q  <= dropped_d;
            fd_prev_q  <= fd_prev_d;
        end
    end

    assign txData       = tx_data_q;
    assign txValid      = tx_valid_q;
    assign bufferBusy   = busy_q;
    assign readoutDone  = done_q;
    assign writeDropped = dropped_q;

`ifdef MEDIAN_OUTBUF_FGCOUNT_EN
    logic [16:0] fg_cnt_q, fg_cnt_d;

    // Cleared on the final accept so it already reads 0 while readoutDone is high.
    always_comb begin
        fg_cnt_d = fg_cnt_q;
        if (last_accept) begin
            fg_cnt_d = '0;
        end else if (wr_en && dataIn) begin
            fg_cnt_d = fg_cnt_q + 17'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fg_cnt_q <= '0;
        end else begin
            fg_cnt_q <= fg_cnt_d;
        end
    end

    assign fgCount = fg_cnt_q;
`else
    logic unused_last_accept;
    assign unused_last_accept = last_accept;
`endif

endmodule
